// File: rtl/move_arbiter.sv
// move_arbiter: tic-tac-toe move arbiter with legality checking, win/draw detection and per-player handshakes.
module move_arbiter #(
  parameter bit FIRST_PLAYER = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] xmove,
  input  logic       xvalid,
  output logic       xready,
  input  logic [8:0] omove,
  input  logic       ovalid,
  output logic       oready,
  output logic [3:0] moveout,
  output logic       movevalid,
  output logic [8:0] xboard,
  output logic [8:0] oboard,
  output logic       turn,
  output logic       illegal,
  output logic       done,
  output logic [1:0] winner
);
  typedef enum logic [1:0] {IDLE, PLAY, CHECK, DONE} state_t;
  state_t     state_q;
  logic [8:0] xboard_q, oboard_q;
  logic [3:0] moveout_q;
  logic       movevalid_q, illegal_q, turn_q, done_q;
  logic [1:0] winner_q;
  logic [8:0] mv_d, mb_d;
  logic [3:0] idx_d;
  logic       vld_d, legal_d, win_d, full_d;
  function automatic logic has_line(input logic [8:0] b);
    return (&b[2:0]) | (&b[5:3]) | (&b[8:6]) |
           (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
           (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
  endfunction
  always_comb begin
    mv_d    = turn_q ? omove : xmove;
    vld_d   = turn_q ? ovalid : xvalid;
    mb_d    = turn_q ? oboard_q : xboard_q;
    legal_d = (mv_d != 9'd0) && ((mv_d & (mv_d - 9'd1)) == 9'd0) && ((mv_d & (xboard_q | oboard_q)) == 9'd0);
    win_d   = has_line(mb_d);
    full_d  = &(xboard_q | oboard_q);
    idx_d   = 4'd0;
    for (int i = 0; i < 9; i++) if (mv_d[i]) idx_d = 4'(i);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      xboard_q    <= 9'd0;
      oboard_q    <= 9'd0;
      moveout_q   <= 4'd0;
      movevalid_q <= 1'b0;
      illegal_q   <= 1'b0;
      turn_q      <= FIRST_PLAYER;
      done_q      <= 1'b0;
      winner_q    <= 2'b00;
    end else begin
      movevalid_q <= 1'b0;
      illegal_q   <= 1'b0;
      if (start) begin
        state_q   <= PLAY;
        xboard_q  <= 9'd0;
        oboard_q  <= 9'd0;
        moveout_q <= 4'd0;
        turn_q    <= FIRST_PLAYER;
        done_q    <= 1'b0;
        winner_q  <= 2'b00;
      end else begin
        case (state_q)
          PLAY: if (vld_d) begin
            if (legal_d) begin
              if (turn_q) oboard_q <= oboard_q | mv_d;
              else xboard_q <= xboard_q | mv_d;
              moveout_q   <= idx_d;
              movevalid_q <= 1'b1;
              state_q     <= CHECK;
            end else begin
              illegal_q <= 1'b1;
            end
          end
          CHECK: begin
            // the mover's board already holds the new square; turn still names the mover
            if (win_d || full_d) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              winner_q <= win_d ? (turn_q ? 2'b10 : 2'b01) : 2'b00;
            end else begin
              turn_q  <= ~turn_q;
              state_q <= PLAY;
            end
          end
          default: ;
        endcase
      end
    end
  end
  assign xready    = (state_q == PLAY) && !turn_q;
  assign oready    = (state_q == PLAY) && turn_q;
  assign moveout   = moveout_q;
  assign movevalid = movevalid_q;
  assign xboard    = xboard_q;
  assign oboard    = oboard_q;
  assign turn      = turn_q;
  assign illegal   = illegal_q;
  assign done      = done_q;
  assign winner    = winner_q;
endmodule

// File: tb/tb_move_arbiter.sv
// tb_move_arbiter: directed scenario tests for move_arbiter with hand-computed expectations.
module tb_move_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [8:0] xmove = 9'd0, omove = 9'd0;
  logic       xvalid = 1'b0, ovalid = 1'b0;
  logic       xready, oready, movevalid, turn, illegal, done;
  logic [3:0] moveout;
  logic [8:0] xboard, oboard;
  logic [1:0] winner;
  int n_chk = 0;
  int n_fail = 0;

  move_arbiter dut (
    .clk(clk), .reset(reset), .start(start),
    .xmove(xmove), .xvalid(xvalid), .xready(xready),
    .omove(omove), .ovalid(ovalid), .oready(oready),
    .moveout(moveout), .movevalid(movevalid),
    .xboard(xboard), .oboard(oboard), .turn(turn),
    .illegal(illegal), .done(done), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // present one request for a single edge, then withdraw it
  task automatic play(input bit p, input logic [8:0] m);
    if (p) begin omove = m; ovalid = 1'b1; end
    else begin xmove = m; xvalid = 1'b1; end
    tick();
    xvalid = 1'b0; ovalid = 1'b0; xmove = 9'd0; omove = 9'd0;
  endtask

  task automatic test_reset;
    #1;
    n_chk++; if (xboard !== 9'd0 || oboard !== 9'd0) begin n_fail++; $display("FAIL rst_boards: got x=%h o=%h exp 0", xboard, oboard); end
    n_chk++; if ({movevalid, illegal, done, turn, xready, oready} !== 6'b0) begin n_fail++; $display("FAIL rst_flags: got %b exp 000000", {movevalid, illegal, done, turn, xready, oready}); end
    n_chk++; if (moveout !== 4'd0 || winner !== 2'b00) begin n_fail++; $display("FAIL rst_mo_win: got mo=%0d w=%b exp 0/00", moveout, winner); end
    @(negedge clk);
    reset = 1'b0;
    xvalid = 1'b1; xmove = 9'h001;
    tick(); tick();
    xvalid = 1'b0; xmove = 9'd0;
    n_chk++; if (xready !== 1'b0 || oready !== 1'b0 || xboard !== 9'd0 || movevalid !== 1'b0) begin n_fail++; $display("FAIL idle_hold: got xr=%b or=%b xb=%h mv=%b exp 0", xready, oready, xboard, movevalid); end
  endtask

  task automatic test_first_move;
    do_start();
    n_chk++; if (xready !== 1'b1 || oready !== 1'b0 || turn !== 1'b0) begin n_fail++; $display("FAIL start_ready: got xr=%b or=%b t=%b exp 1/0/0", xready, oready, turn); end
    play(0, 9'h010);
    n_chk++; if (movevalid !== 1'b1 || moveout !== 4'd4) begin n_fail++; $display("FAIL first_mv: got mv=%b mo=%0d exp 1/4", movevalid, moveout); end
    n_chk++; if (xboard !== 9'h010 || xready !== 1'b0 || oready !== 1'b0) begin n_fail++; $display("FAIL first_check: got xb=%h xr=%b or=%b exp 010/0/0", xboard, xready, oready); end
    tick();
    n_chk++; if (oready !== 1'b1 || turn !== 1'b1 || movevalid !== 1'b0) begin n_fail++; $display("FAIL first_next: got or=%b t=%b mv=%b exp 1/1/0", oready, turn, movevalid); end
  endtask

  task automatic test_occupied;
    play(1, 9'h010);
    n_chk++; if (illegal !== 1'b1 || oboard !== 9'd0 || turn !== 1'b1) begin n_fail++; $display("FAIL occ_illegal: got il=%b ob=%h t=%b exp 1/000/1", illegal, oboard, turn); end
    n_chk++; if (oready !== 1'b1 || movevalid !== 1'b0) begin n_fail++; $display("FAIL occ_stay: got or=%b mv=%b exp 1/0", oready, movevalid); end
    play(1, 9'h001);
    n_chk++; if (illegal !== 1'b0 || movevalid !== 1'b1 || moveout !== 4'd0 || oboard !== 9'h001) begin n_fail++; $display("FAIL retry: got il=%b mv=%b mo=%0d ob=%h exp 0/1/0/001", illegal, movevalid, moveout, oboard); end
    tick();
    n_chk++; if (xready !== 1'b1 || turn !== 1'b0) begin n_fail++; $display("FAIL retry_next: got xr=%b t=%b exp 1/0", xready, turn); end
  endtask

  task automatic test_x_wins;
    logic [8:0] seq [5];
    seq = '{9'h001, 9'h002, 9'h010, 9'h004, 9'h100};
    do_start();
    for (int i = 0; i < 5; i++) begin
      play(i[0], seq[i]);
      if (i == 4) begin
        n_chk++; if (moveout !== 4'd8 || done !== 1'b0) begin n_fail++; $display("FAIL win_check: got mo=%0d d=%b exp 8/0", moveout, done); end
      end
      tick();
    end
    n_chk++; if (done !== 1'b1 || winner !== 2'b01) begin n_fail++; $display("FAIL x_win: got d=%b w=%b exp 1/01", done, winner); end
    n_chk++; if (xboard !== 9'h111 || oboard !== 9'h006) begin n_fail++; $display("FAIL win_boards: got x=%h o=%h exp 111/006", xboard, oboard); end
    play(1, 9'h008);
    play(0, 9'h008);
    tick();
    n_chk++; if (xready !== 1'b0 || oready !== 1'b0 || done !== 1'b1 || winner !== 2'b01 || oboard !== 9'h006 || moveout !== 4'd8) begin n_fail++; $display("FAIL done_hold: got xr=%b or=%b d=%b w=%b ob=%h mo=%0d", xready, oready, done, winner, oboard, moveout); end
  endtask

  task automatic test_draw;
    logic [8:0] seq [9];
    seq = '{9'h001, 9'h002, 9'h004, 9'h010, 9'h008, 9'h020, 9'h080, 9'h040, 9'h100};
    do_start();
    for (int i = 0; i < 9; i++) begin
      play(i[0], seq[i]);
      tick();
      if (i == 7) begin
        n_chk++; if (done !== 1'b0 || xready !== 1'b1) begin n_fail++; $display("FAIL draw_mid: got d=%b xr=%b exp 0/1", done, xready); end
      end
    end
    n_chk++; if (done !== 1'b1 || winner !== 2'b00) begin n_fail++; $display("FAIL draw: got d=%b w=%b exp 1/00", done, winner); end
    n_chk++; if ((xboard | oboard) !== 9'h1FF || xboard !== 9'h18D || (xboard & oboard) !== 9'd0) begin n_fail++; $display("FAIL draw_boards: got x=%h o=%h exp 18d/072", xboard, oboard); end
  endtask

  task automatic test_bad_patterns;
    do_start();
    play(0, 9'h003);
    n_chk++; if (illegal !== 1'b1 || xboard !== 9'd0 || movevalid !== 1'b0) begin n_fail++; $display("FAIL two_hot: got il=%b xb=%h mv=%b exp 1/000/0", illegal, xboard, movevalid); end
    play(0, 9'h000);
    n_chk++; if (illegal !== 1'b1 || xboard !== 9'd0 || turn !== 1'b0) begin n_fail++; $display("FAIL zero_req: got il=%b xb=%h t=%b exp 1/000/0", illegal, xboard, turn); end
    play(1, 9'h001);
    n_chk++; if (illegal !== 1'b0 || oboard !== 9'd0 || movevalid !== 1'b0 || xready !== 1'b1) begin n_fail++; $display("FAIL off_turn: got il=%b ob=%h mv=%b xr=%b exp 0/000/0/1", illegal, oboard, movevalid, xready); end
  endtask

  task automatic test_start_priority;
    do_start();
    play(0, 9'h010); tick();
    play(1, 9'h001); tick();
    start = 1'b1; xvalid = 1'b1; xmove = 9'h100;
    tick();
    start = 1'b0; xvalid = 1'b0; xmove = 9'd0;
    n_chk++; if (xboard !== 9'd0 || oboard !== 9'd0 || movevalid !== 1'b0) begin n_fail++; $display("FAIL start_prio: got x=%h o=%h mv=%b exp 0/0/0", xboard, oboard, movevalid); end
    n_chk++; if (turn !== 1'b0 || xready !== 1'b1 || moveout !== 4'd0) begin n_fail++; $display("FAIL start_state: got t=%b xr=%b mo=%0d exp 0/1/0", turn, xready, moveout); end
  endtask

  task automatic test_reset_in_check;
    play(0, 9'h040); tick();
    play(1, 9'h004);
    n_chk++; if (movevalid !== 1'b1 || turn !== 1'b1) begin n_fail++; $display("FAIL pre_rst: got mv=%b t=%b exp 1/1", movevalid, turn); end
    reset = 1'b1;
    #1;
    n_chk++; if (movevalid !== 1'b0 || xboard !== 9'd0 || oboard !== 9'd0 || moveout !== 4'd0 || turn !== 1'b0) begin n_fail++; $display("FAIL async_rst: got mv=%b x=%h o=%h mo=%0d t=%b", movevalid, xboard, oboard, moveout, turn); end
    tick();
    @(negedge clk);
    reset = 1'b0;
    tick(); tick();
    n_chk++; if (xready !== 1'b0 || oready !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_idle: got xr=%b or=%b d=%b exp 0/0/0", xready, oready, done); end
  endtask

  initial begin
    test_reset();
    test_first_move();
    test_occupied();
    test_x_wins();
    test_draw();
    test_bad_patterns();
    test_start_priority();
    test_reset_in_check();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
